// File: rtl/inst_axil_rd_slave_pkg.sv
// AXI-lite response codes shared by the IFU-side AXI-lite blocks.
package inst_axil_rd_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_resp_fifo.sv
// Small response FIFO with a combinational head output; pointers carry a wrap bit
// so full and empty can be told apart without a separate count.
module axil_resp_fifo #(
    parameter int DATA_LEN   = 34,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wen,
    input  logic                ren,
    output logic                empty,
    output logic                full,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata
);

    localparam int PTR_W = DEPTH_LOG2 + 1;

    logic [DATA_LEN-1:0] mem [1 << DEPTH_LOG2];
    logic [PTR_W-1:0]    wptr_reg;
    logic [PTR_W-1:0]    rptr_reg;

    assign empty = (wptr_reg == rptr_reg);
    assign full  = (wptr_reg[DEPTH_LOG2] != rptr_reg[DEPTH_LOG2]) &&
                   (wptr_reg[DEPTH_LOG2-1:0] == rptr_reg[DEPTH_LOG2-1:0]);
    assign rdata = mem[rptr_reg[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[wptr_reg[DEPTH_LOG2-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (wen) begin
                wptr_reg <= wptr_reg + PTR_W'(1);
            end
            if (ren && !empty) begin
                rptr_reg <= rptr_reg + PTR_W'(1);
            end
        end
    end

    // Upstream credit accounting must make this impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(wen && full && !ren))
        else $error("axil_resp_fifo overflow");

endmodule

// File: rtl/inst_axil_rd_slave.sv
// AXI-lite read-only instruction memory port: in-order responses with a fixed
// read latency, credit-limited to OUTSTANDING in-flight requests.
module inst_axil_rd_slave
    import inst_axil_rd_slave_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          DEPTH_LOG2  = 12,
    parameter int          RD_LATENCY  = 2,
    parameter int          OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [63:0]           araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [1:0]            rresp,
    output logic [31:0]           rdata,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam int PEND_W    = $clog2(OUTSTANDING) + 1;
    localparam int FIFO_LOG2 = $clog2(OUTSTANDING);

    logic [PEND_W-1:0]     pending_reg;
    logic [PEND_W-1:0]     pending_next;
    logic                  ar_hs;
    logic                  r_hs;
    logic [63:0]           off;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] word;
    logic [31:0]           mem [1 << DEPTH_LOG2];
    logic                  tail_valid;
    logic [1:0]            tail_resp;
    logic [31:0]           tail_raw;
    logic [31:0]           tail_data;
    logic                  fifo_empty;
    logic                  fifo_full_unused;
    logic [33:0]           fifo_head;
    logic                  unused_off_bits;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    assign off             = araddr - BASE_ADDR;
    assign hit             = (araddr >= BASE_ADDR) && (off[63:DEPTH_LOG2+2] == '0);
    assign word            = off[DEPTH_LOG2+1:2];
    assign unused_off_bits = ^off[1:0];

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // The pipeline only ever moves forward; back-pressure is absorbed by the
    // FIFO, which the pending credit guarantees has room.
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign tail_valid = ar_hs;
            assign tail_resp  = hit ? RESP_OKAY : RESP_DECERR;
            assign tail_raw   = mem[word];
        end else begin : g_pipe
            localparam int NSTG = RD_LATENCY - 1;

            logic        valid_reg [NSTG];
            logic [1:0]  resp_reg  [NSTG];
            logic [31:0] data_reg  [NSTG];

            // Stage 1 data is the registered SRAM read, enabled only on a hit.
            always_ff @(posedge clk) begin
                if (ar_hs && hit) begin
                    data_reg[0] <= mem[word];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[0] <= 1'b0;
                    resp_reg[0]  <= RESP_OKAY;
                end else begin
                    valid_reg[0] <= ar_hs;
                    resp_reg[0]  <= hit ? RESP_OKAY : RESP_DECERR;
                end
            end

            for (genvar gi = 1; gi < NSTG; gi++) begin : g_stage
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        valid_reg[gi] <= 1'b0;
                        resp_reg[gi]  <= RESP_OKAY;
                    end else begin
                        valid_reg[gi] <= valid_reg[gi-1];
                        resp_reg[gi]  <= resp_reg[gi-1];
                    end
                end

                always_ff @(posedge clk) begin
                    data_reg[gi] <= data_reg[gi-1];
                end
            end

            assign tail_valid = valid_reg[NSTG-1];
            assign tail_resp  = resp_reg[NSTG-1];
            assign tail_raw   = data_reg[NSTG-1];
        end
    endgenerate

    // Misses never load the data register, so its stale value is masked here.
    assign tail_data = (tail_resp == RESP_OKAY) ? tail_raw : 32'd0;

    axil_resp_fifo #(
        .DATA_LEN   (34),
        .DEPTH_LOG2 (FIFO_LOG2)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (tail_valid),
        .ren   (r_hs),
        .empty (fifo_empty),
        .full  (fifo_full_unused),
        .wdata ({tail_resp, tail_data}),
        .rdata (fifo_head)
    );

    assign rvalid          = !fifo_empty;
    assign {rresp, rdata}  = fifo_empty ? 34'd0 : fifo_head;
    assign arready         = (pending_reg < PEND_W'(OUTSTANDING));

    always_comb begin
        pending_next = pending_reg;
        case ({ar_hs, r_hs})
            2'b10:   pending_next = pending_reg + PEND_W'(1);
            2'b01:   pending_next = pending_reg - PEND_W'(1);
            default: pending_next = pending_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

endmodule

// File: tb/tb_inst_axil_rd_slave.sv
// Directed bench for inst_axil_rd_slave: a negedge monitor pushes expected beats
// on AR handshakes and pops/compares them on R handshakes.
`timescale 1ns/1ps
module tb_inst_axil_rd_slave;

    localparam logic [63:0] BASE = 64'h8000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } beat_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        arvalid   = 1'b0;
    logic        arready;
    logic [63:0] araddr    = 64'd0;
    logic        rvalid;
    logic        rready    = 1'b1;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        load_en   = 1'b0;
    logic [11:0] load_addr = 12'd0;
    logic [31:0] load_data = 32'd0;

    beat_t       exp_q[$];
    beat_t       got_q[$];
    beat_t       mon_e;
    logic [31:0] model_mem [4096];
    int          checks = 0;
    int          errors = 0;
    int          beats  = 0;
    int          b0;
    int          acc;

    logic [63:0] t4_addr [4];
    logic [1:0]  t4_resp [4];
    logic [31:0] t4_data [4];

    always #5 clk = ~clk;

    inst_axil_rd_slave #(
        .BASE_ADDR   (BASE),
        .DEPTH_LOG2  (12),
        .RD_LATENCY  (2),
        .OUTSTANDING (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rresp     (rresp),
        .rdata     (rdata),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t model(input logic [63:0] a);
        logic [63:0] o;
        beat_t       b;
        o = a - BASE;
        if (a >= BASE && o[63:14] == 50'd0) begin
            b.data = model_mem[o[13:2]];
            b.resp = 2'b00;
        end else begin
            b.data = 32'd0;
            b.resp = 2'b11;
        end
        return b;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Handshakes complete at the next posedge; inputs are stable at the negedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    check("r_unexpected", rvalid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rdata", rdata, mon_e.data);
                    check("rresp", rresp, mon_e.resp);
                end
                got_q.push_back(beat_t'{data: rdata, resp: rresp});
                beats++;
                $display("R beat %0d: rdata=%08h rresp=%0d", beats, rdata, rresp);
            end
            if (arvalid && arready) begin
                exp_q.push_back(model(araddr));
            end
        end
        if (load_en) begin
            model_mem[load_addr] = load_data;
        end
    end

    initial begin
        // Preload under reset
        repeat (2) cyc();
        for (int i = 0; i < 32; i++) begin
            load_en   = 1'b1;
            load_addr = 12'(i);
            load_data = (i == 0) ? 32'h0000_0013 : {16'hA5A5, 16'(i)};
            cyc();
        end
        load_en = 1'b0;
        @(negedge clk);
        check("reset_arready", arready, 1'b1);
        check("reset_rvalid", rvalid, 1'b0);
        check("reset_rresp", rresp, 2'b00);
        check("reset_rdata", rdata, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single read, latency 2
        arvalid = 1'b1;
        araddr  = BASE;
        @(negedge clk);
        check("t1_arready", arready, 1'b1);
        cyc();
        arvalid = 1'b0;
        @(negedge clk);
        check("t1_rvalid_T1", rvalid, 1'b0);
        check("t1_arready_T1", arready, 1'b1);
        cyc();
        @(negedge clk);
        check("t1_rvalid_T2", rvalid, 1'b1);
        check("t1_rdata", rdata, 32'h0000_0013);
        cyc();
        cyc();

        // Streaming 16 reads
        b0 = beats;
        arvalid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) araddr = BASE + 64'(4 * i);
            else arvalid = 1'b0;
            @(negedge clk);
            if (i < 16) check("t2_arready", arready, 1'b1);
            if (i >= 2) check("t2_stream_rvalid", rvalid, 1'b1);
            cyc();
        end
        @(negedge clk);
        check("t2_rvalid_end", rvalid, 1'b0);
        check("t2_beats", beats - b0, 16);
        cyc();

        // Backpressure
        rready  = 1'b0;
        arvalid = 1'b1;
        acc     = 0;
        for (int k = 0; k < 8; k++) begin
            araddr = BASE + 64'(4 * (20 + acc));
            @(negedge clk);
            check("t3_arready", arready, (k < 4));
            if (k >= 2) begin
                check("t3_head_rvalid", rvalid, 1'b1);
                check("t3_head_stable", rdata, exp_q[0].data);
            end
            if (arvalid && arready) acc++;
            cyc();
        end
        check("t3_accepts", acc, 4);
        arvalid = 1'b0;
        rready  = 1'b1;
        b0 = beats;
        @(negedge clk);
        check("t3_arready_first_r", arready, 1'b0);
        check("t3_rvalid_first_r", rvalid, 1'b1);
        cyc();
        @(negedge clk);
        check("t3_arready_after_r", arready, 1'b1);
        repeat (4) cyc();
        @(negedge clk);
        check("t3_beats", beats - b0, 4);
        check("t3_rvalid_end", rvalid, 1'b0);
        cyc();

        // Decode misses interleaved with hits
        got_q.delete();
        t4_addr = '{64'h7FFF_FFFC, BASE + 64'd8, BASE + 64'd16384, BASE + 64'd12};
        t4_resp = '{2'b11, 2'b00, 2'b11, 2'b00};
        t4_data = '{32'd0, 32'hA5A5_0002, 32'd0, 32'hA5A5_0003};
        for (int i = 0; i < 4; i++) begin
            arvalid = 1'b1;
            araddr  = t4_addr[i];
            cyc();
        end
        arvalid = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        check("t4_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t4_resp", got_q[i].resp, t4_resp[i]);
            check("t4_data", got_q[i].data, t4_data[i]);
        end
        cyc();

        // Same-cycle load and read of word 5
        got_q.delete();
        load_en   = 1'b1;
        load_addr = 12'd5;
        load_data = 32'hDEAD_BEEF;
        arvalid   = 1'b1;
        araddr    = BASE + 64'd20;
        cyc();
        load_en = 1'b0;
        cyc();
        arvalid = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        check("t5_count", got_q.size(), 2);
        check("t5_old", got_q[0].data, 32'hA5A5_0005);
        check("t5_new", got_q[1].data, 32'hDEAD_BEEF);
        cyc();

        // Async reset with requests in flight
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            arvalid = 1'b1;
            araddr  = BASE + 64'(4 * (6 + i));
            cyc();
        end
        arvalid = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("t6_rvalid_before", rvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rvalid_in_reset", rvalid, 1'b0);
        check("t6_arready_in_reset", arready, 1'b1);
        check("t6_rdata_in_reset", rdata, 32'd0);
        exp_q.delete();
        cyc();
        cyc();
        rst_n   = 1'b1;
        rready  = 1'b1;
        b0      = beats;
        arvalid = 1'b1;
        araddr  = BASE + 64'd4;
        @(negedge clk);
        check("t6_first_ar", arready, 1'b1);
        cyc();
        arvalid = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        check("t6_beats", beats - b0, 1);
        check("t6_rvalid_end", rvalid, 1'b0);

        // Drain, bounded
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) cyc();
        check("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
